// File: rtl/vga_sync_pulse_gen_pkg.sv
// Shared 640x480@60 raster timing used by the sync and porch stages.
// Totals are derived from the porch/pulse widths, so they cannot disagree.
package vga_sync_pulse_gen_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_PULSE  = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  =
    H_ACTIVE + H_FRONT + H_PULSE + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_PULSE  = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  =
    V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam int VGA_COUNT_W = 10;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic frame_start;
  } sync_t;

  localparam sync_t SYNC_RST = '{
    h_sync:      1'b1,
    v_sync:      1'b1,
    frame_start: 1'b0
  };

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MAX counter; o_Wrap flags the enabled step from MAX-1 back to 0.
module vga_wrap_counter
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int MAX = H_TOTAL,
  parameter int W   = VGA_COUNT_W
) (
  input  logic         CLK,
  input  logic         i_Rst,
  input  logic         i_En,
  output logic [W-1:0] o_Count,
  output logic         o_Wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign o_Wrap = i_En && (o_Count == LAST);

  always_ff @(posedge CLK) begin
    if (i_Rst) begin
      o_Count <= '0;
    end else if (o_Wrap) begin
      o_Count <= '0;
    end else if (i_En) begin
      o_Count <= o_Count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_pulse_gen.sv
// Free-running raster generator: column/row counts, active-area
// syncs and a frame-start strobe, all registered.
module vga_sync_pulse_gen
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int TOTAL_COLS  = H_TOTAL,
  parameter int TOTAL_ROWS  = V_TOTAL,
  parameter int ACTIVE_COLS = H_ACTIVE,
  parameter int ACTIVE_ROWS = V_ACTIVE,
  parameter int COUNT_W     = VGA_COUNT_W
) (
  input  logic               CLK,
  input  logic               i_Rst,
  input  logic               i_En,
  output logic               o_H_Sync,
  output logic               o_V_Sync,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count,
  output logic               o_Frame_Start
);

  localparam logic [COUNT_W-1:0] ACOL =
    COUNT_W'(ACTIVE_COLS);
  localparam logic [COUNT_W-1:0] AROW =
    COUNT_W'(ACTIVE_ROWS);

  logic               col_wrap;
  logic               row_wrap;
  logic [COUNT_W-1:0] col;
  logic [COUNT_W-1:0] row;
  logic [COUNT_W-1:0] col_nxt;
  logic [COUNT_W-1:0] row_nxt;
  sync_t              sync_q;

  vga_wrap_counter #(
    .MAX (TOTAL_COLS),
    .W   (COUNT_W)
  ) u_col (
    .CLK     (CLK),
    .i_Rst   (i_Rst),
    .i_En    (i_En),
    .o_Count (col),
    .o_Wrap  (col_wrap)
  );

  // col_wrap already carries i_En, so rows step once per line.
  vga_wrap_counter #(
    .MAX (TOTAL_ROWS),
    .W   (COUNT_W)
  ) u_row (
    .CLK     (CLK),
    .i_Rst   (i_Rst),
    .i_En    (col_wrap),
    .o_Count (row),
    .o_Wrap  (row_wrap)
  );

  // Look-ahead counts keep the registered syncs aligned with the counts.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (col_wrap) begin
      col_nxt = '0;
    end else if (i_En) begin
      col_nxt = col + 1'b1;
    end
    if (row_wrap) begin
      row_nxt = '0;
    end else if (col_wrap) begin
      row_nxt = row + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Rst) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q.h_sync      <= col_nxt < ACOL;
      sync_q.v_sync      <= row_nxt < AROW;
      sync_q.frame_start <= row_wrap;
    end
  end

  assign o_H_Sync      = sync_q.h_sync;
  assign o_V_Sync      = sync_q.v_sync;
  assign o_Frame_Start = sync_q.frame_start;
  assign o_Col_Count   = col;
  assign o_Row_Count   = row;

endmodule

// File: tb/tb_vga_sync_pulse_gen.sv
// Scoreboard bench: full-size and shrunk raster instances share stimulus
// and are checked against a linear-position reference model.
module tb_vga_sync_pulse_gen;

  localparam int DC = 800, DR = 525, DAC = 640, DAR = 480, DW = 10;
  localparam int SC = 12, SR = 7, SAC = 9, SAR = 5, SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic          d_h, d_v, d_f;
  logic [DW-1:0] d_c, d_r;
  logic          s_h, s_v, s_f;
  logic [SW-1:0] s_c, s_r;

  always #5 clk = ~clk;

  vga_sync_pulse_gen dut_d (
    .CLK           (clk),
    .i_Rst         (rst),
    .i_En          (en),
    .o_H_Sync      (d_h),
    .o_V_Sync      (d_v),
    .o_Col_Count   (d_c),
    .o_Row_Count   (d_r),
    .o_Frame_Start (d_f)
  );

  vga_sync_pulse_gen #(
    .TOTAL_COLS  (SC),
    .TOTAL_ROWS  (SR),
    .ACTIVE_COLS (SAC),
    .ACTIVE_ROWS (SAR),
    .COUNT_W     (SW)
  ) dut_s (
    .CLK           (clk),
    .i_Rst         (rst),
    .i_En          (en),
    .o_H_Sync      (s_h),
    .o_V_Sync      (s_v),
    .o_Col_Count   (s_c),
    .o_Row_Count   (s_r),
    .o_Frame_Start (s_f)
  );

  typedef struct {
    int col;
    int row;
    bit h;
    bit v;
    bit f;
  } exp_t;

  typedef struct {
    exp_t d;
    exp_t s;
  } item_t;

  item_t q[$];
  int    d_pos = 0;
  int    s_pos = 0;
  int    checks = 0;
  int    errors = 0;
  bit    stim_done = 1'b0;

  // Raster as one linear pixel index modulo the frame size.
  function automatic int step(input int pos, input int c, input int r,
                              input bit rs, input bit e, output bit fs);
    int np;
    fs = 1'b0;
    np = pos;
    if (rs) begin
      np = 0;
    end else if (e) begin
      np = (pos + 1) % (c * r);
      fs = (np == 0);
    end
    return np;
  endfunction

  function automatic exp_t view(input int pos, input int c,
                                input int ac, input int ar, input bit fs);
    exp_t x;
    x.col = pos % c;
    x.row = pos / c;
    x.h   = x.col < ac;
    x.v   = x.row < ar;
    x.f   = fs;
    return x;
  endfunction

  task automatic cyc(input bit r, input bit e);
    item_t it;
    bit    fd, fs;
    @(negedge clk);
    rst = r;
    en  = e;
    d_pos = step(d_pos, DC, DR, r, e, fd);
    s_pos = step(s_pos, SC, SR, r, e, fs);
    it.d = view(d_pos, DC, DAC, DAR, fd);
    it.s = view(s_pos, SC, SAC, SAR, fs);
    q.push_back(it);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d",
                 name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("d_col",   int'(d_c), it.d.col);
        chk("d_row",   int'(d_r), it.d.row);
        chk("d_hsync", int'(d_h), int'(it.d.h));
        chk("d_vsync", int'(d_v), int'(it.d.v));
        chk("d_fstart", int'(d_f), int'(it.d.f));
        chk("s_col",   int'(s_c), it.s.col);
        chk("s_row",   int'(s_r), it.s.row);
        chk("s_hsync", int'(s_h), int'(it.s.h));
        chk("s_vsync", int'(s_v), int'(it.s.v));
        chk("s_fstart", int'(s_f), int'(it.s.f));
      end
    end
  end

  initial begin : stim
    bit hit;
    repeat (3) cyc(1'b1, 1'b1);
    repeat (1700) cyc(1'b0, 1'b1);

    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (d_pos % DC == 638) begin
        hit = 1'b1;
        break;
      end
      cyc(1'b0, 1'b1);
    end
    chk("reach_col_638", int'(hit), 1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (200) cyc(1'b0, 1'b1);

    cyc(1'b1, 1'b1);
    repeat (300) cyc(1'b0, 1'b1);

    for (int i = 0; i < 20000; i++) begin
      cyc(($urandom % 500) == 0, ($urandom % 4) != 0);
    end
    stim_done = 1'b1;
  end

  initial begin : finisher
    int n;
    wait (stim_done);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_pulse_gen.md
Name: vga_sync_pulse_gen

Overview:
- Free-running raster timing generator for the VGA path.
- Produces raw active-area H/V sync pulses, plus column/row counts and a frame-start strobe.
- Outputs feed the porch-insertion stage directly downstream; column/row counts are exported for pixel generators.
- Default timing: 800x525 total, 640x480 visible.

Parameters:
- TOTAL_COLS, 800, horizontal period in pixel clocks
- TOTAL_ROWS, 525, vertical period in lines
- ACTIVE_COLS, 640, visible columns; must be < TOTAL_COLS
- ACTIVE_ROWS, 480, visible rows; must be < TOTAL_ROWS
- COUNT_W, 10, counter width; must satisfy 2^COUNT_W >= max(TOTAL_COLS, TOTAL_ROWS)

Ports:
- CLK  input  1  system/pixel clock, all logic on rising edge
- i_Rst  input  1  reset, synchronous, active-high
- i_En  input  1  pixel-advance enable; counters step only when 1
- o_H_Sync  output  1  high while column count < ACTIVE_COLS
- o_V_Sync  output  1  high while row count < ACTIVE_ROWS
- o_Col_Count  output  COUNT_W  current column, 0..TOTAL_COLS-1
- o_Row_Count  output  COUNT_W  current row, 0..TOTAL_ROWS-1
- o_Frame_Start  output  1  one-clock strobe when counters wrap to (0,0)

Behaviour:
- Interface is fixed: one clock, CLK; reset i_Rst is synchronous and active-high.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values (the cycle after i_Rst is sampled high):
  - o_Col_Count=0, o_Row_Count=0
  - o_H_Sync=1, o_V_Sync=1
  - o_Frame_Start=0
- Reset dominates i_En. Reset mid-frame returns to (0,0) on the next edge; no frame-start strobe is issued for a reset.
- Column counter, when i_En=1:
  - if col==TOTAL_COLS-1, then col<=0;
  - else col<=col+1.
- Row counter:
  - advances only when i_En=1 and col==TOTAL_COLS-1;
  - if row==TOTAL_ROWS-1 at that point, then row<=0;
  - else row<=row+1.
- i_En=0: counters, syncs and all other state hold; o_Frame_Start forced 0.
- Sync alignment: o_H_Sync and o_V_Sync are computed from the next-count values, so in every cycle:
  - o_H_Sync == (o_Col_Count < ACTIVE_COLS)
  - o_V_Sync == (o_Row_Count < ACTIVE_ROWS)
  - There is zero latency between counts and syncs.
- o_H_Sync is independent of row; H pulses continue through vertical blanking.
- o_Frame_Start is 1 for exactly one CLK after an enabled step from (TOTAL_COLS-1, TOTAL_ROWS-1) to (0,0), and 0 otherwise.
  - It is not stretched if i_En drops on the following cycle.
- Arithmetic: unsigned, COUNT_W bits. Comparisons use the full width; no wrap beyond the TOTAL_* bounds is reachable.
- Simultaneous column and row wrap is the frame-end case: both counters go to 0 on the same edge.

Decomposition:
- Shared VGA timing package holds the 640x480 constants for total, active, front porch, back porch and pulse widths. This stage and the porch stage both import it, so the timings cannot diverge.
- One natural sub-module: vga_wrap_counter.
  - Parameters: MAX, W. Ports: CLK, i_Rst, i_En, o_Count, o_Wrap.
  - Instantiated twice. The row instance is enabled by i_En AND the column instance's o_Wrap.

Test Plan:
- Reset: hold i_Rst=1 for 3 clocks with i_En=1 -> col=0, row=0, H=1, V=1, FrameStart=0. Release -> col counts 1,2,3 on successive edges.
- Horizontal edge: i_En=1 constant.
  - col 639 -> 640: H goes 1->0 on the same edge.
  - col 799 -> 0: H returns to 1 and row increments 0 -> 1.
- Vertical edge:
  - row 479 -> 480 at col wrap: V goes 1->0.
  - H keeps pulsing with the 800-clock period during rows 480..524.
- Frame wrap: (799,524) -> (0,0). FrameStart=1 for exactly one clock; V=1, H=1. Next FrameStart occurs exactly 420000 enabled clocks later.
- Enable stall: i_En toggled 1,0,0,1 around col 639 -> col and H hold during the 0 cycles; FrameStart never asserted while i_En=0.
- Mid-frame reset: at (321,200), assert i_Rst for one clock -> next edge gives (0,0), H=1, V=1, FrameStart=0; counting resumes normally.
